// File: rtl/otter_rob_pkg.sv
// Shared types and constants for the OTTER reorder buffer.
// Provides the per-entry record and default sizing constants.
package otter_rob_pkg;

   localparam int ROB_DEPTH_DEFAULT = 8;
   localparam int REG_ADDR_W        = 5;
   localparam int XLEN              = 32;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  wen;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } rob_entry_t;

endpackage

// File: rtl/otter_rob_ptr.sv
// Wrap-around ROB pointer: advance by 0/1/2 per cycle, sync clear.
// Ports: clock, reset_n, clear, inc[1:0] in; ptr[W-1:0] out.
module otter_rob_ptr #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic [1:0]               inc,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   localparam int W = $clog2(DEPTH);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // DEPTH is a power of two, so truncation is the modulo wrap.
   always_comb begin
      ptr_d = ptr_q + W'(inc);
      if (clear) begin
         ptr_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/otter_rob_commit.sv
// Dual-dispatch ROB: 2 allocs/cycle, 2 completion ports, 1 in-order
// retire into the register file write port (rf_we/rf_waddr/rf_wdata).
// Ports: clock, reset_n, flush; alloc_* (dispatch); cmp_* (writeback);
// rf_* (retire); rob_empty; retire_count when ROB_RETIRE_CNT_EN defined.
module otter_rob_commit
   import otter_rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH_DEFAULT,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  alloc_valid_0,
   input  logic                  alloc_valid_1,
   input  logic [REG_ADDR_W-1:0] alloc_rd_0,
   input  logic [REG_ADDR_W-1:0] alloc_rd_1,
   input  logic                  alloc_wen_0,
   input  logic                  alloc_wen_1,
   output logic                  alloc_ready,
   output logic [TAG_W-1:0]      alloc_tag_0,
   output logic [TAG_W-1:0]      alloc_tag_1,
   input  logic                  cmp_valid_0,
   input  logic                  cmp_valid_1,
   input  logic [TAG_W-1:0]      cmp_tag_0,
   input  logic [TAG_W-1:0]      cmp_tag_1,
   input  logic [XLEN-1:0]       cmp_data_0,
   input  logic [XLEN-1:0]       cmp_data_1,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
`ifdef ROB_RETIRE_CNT_EN
   output logic [31:0]           retire_count,
`endif
   output logic                  rob_empty
);

   localparam int CW = TAG_W + 1;

   rob_entry_t            ent_q [DEPTH];
   rob_entry_t            ent_d [DEPTH];
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  rf_we_q;
   logic                  rf_we_d;
   logic [REG_ADDR_W-1:0] rf_waddr_q;
   logic [REG_ADDR_W-1:0] rf_waddr_d;
   logic [XLEN-1:0]       rf_wdata_q;
   logic [XLEN-1:0]       rf_wdata_d;

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic             alloc_fire;
   logic             commit;
   logic [1:0]       n_alloc;
   rob_entry_t       head_ent;

   // Registered count only: a slot freed this cycle is not reusable yet.
   assign alloc_ready = (count_q <= CW'(DEPTH - 2));
   assign alloc_tag_0 = tail;
   assign alloc_tag_1 = tail + TAG_W'(alloc_valid_0);
   assign alloc_fire  = alloc_ready && !flush;
   assign n_alloc     = alloc_fire
                      ? ({1'b0, alloc_valid_0} + {1'b0, alloc_valid_1})
                      : 2'd0;
   assign head_ent    = ent_q[head];
   assign commit      = head_ent.valid && head_ent.done && !flush;

   otter_rob_ptr #(.DEPTH(DEPTH)) u_head (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (flush),
      .inc     ({1'b0, commit}),
      .ptr     (head)
   );

   otter_rob_ptr #(.DEPTH(DEPTH)) u_tail (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (flush),
      .inc     (n_alloc),
      .ptr     (tail)
   );

   // Completions test the registered valid bit, which filters both stale
   // tags and tags being allocated in this same cycle. Port 1 is applied
   // last so it wins a same-tag collision.
   always_comb begin
      ent_d = ent_q;
      if (commit) begin
         ent_d[head].valid = 1'b0;
      end
      if (cmp_valid_0 && ent_q[cmp_tag_0].valid) begin
         ent_d[cmp_tag_0].done = 1'b1;
         ent_d[cmp_tag_0].data = cmp_data_0;
      end
      if (cmp_valid_1 && ent_q[cmp_tag_1].valid) begin
         ent_d[cmp_tag_1].done = 1'b1;
         ent_d[cmp_tag_1].data = cmp_data_1;
      end
      if (alloc_fire && alloc_valid_0) begin
         ent_d[alloc_tag_0] = '{valid: 1'b1, done: 1'b0,
                                wen: alloc_wen_0, rd: alloc_rd_0,
                                data: '0};
      end
      if (alloc_fire && alloc_valid_1) begin
         ent_d[alloc_tag_1] = '{valid: 1'b1, done: 1'b0,
                                wen: alloc_wen_1, rd: alloc_rd_1,
                                data: '0};
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].valid = 1'b0;
            ent_d[i].done  = 1'b0;
         end
      end
   end

   always_comb begin
      count_d    = count_q + CW'(n_alloc) - CW'(commit);
      rf_we_d    = commit && head_ent.wen && (head_ent.rd != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (commit) begin
         rf_waddr_d = head_ent.rd;
         rf_wdata_d = head_ent.data;
      end
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         ent_q      <= ent_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign rob_empty = (count_q == '0);

`ifdef ROB_RETIRE_CNT_EN
   // Counts every retirement, including ones that do not write the file.
   logic [31:0] retire_count_q;
   logic [31:0] retire_count_d;

   always_comb begin
      retire_count_d = retire_count_q + 32'(commit);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retire_count_q <= '0;
      end else begin
         retire_count_q <= retire_count_d;
      end
   end

   assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_otter_rob_commit.sv
// Self-checking bench for otter_rob_commit (DEPTH=8).
// Directed scenarios plus random traffic against a queue-based model.
module tb_otter_rob_commit;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        alloc_valid_0 = 1'b0, alloc_valid_1 = 1'b0;
   logic [4:0]  alloc_rd_0 = '0, alloc_rd_1 = '0;
   logic        alloc_wen_0 = 1'b0, alloc_wen_1 = 1'b0;
   logic        alloc_ready;
   logic [2:0]  alloc_tag_0, alloc_tag_1;
   logic        cmp_valid_0 = 1'b0, cmp_valid_1 = 1'b0;
   logic [2:0]  cmp_tag_0 = '0, cmp_tag_1 = '0;
   logic [31:0] cmp_data_0 = '0, cmp_data_1 = '0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rob_empty;
`ifdef ROB_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   otter_rob_commit #(.DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .flush         (flush),
      .alloc_valid_0 (alloc_valid_0),
      .alloc_valid_1 (alloc_valid_1),
      .alloc_rd_0    (alloc_rd_0),
      .alloc_rd_1    (alloc_rd_1),
      .alloc_wen_0   (alloc_wen_0),
      .alloc_wen_1   (alloc_wen_1),
      .alloc_ready   (alloc_ready),
      .alloc_tag_0   (alloc_tag_0),
      .alloc_tag_1   (alloc_tag_1),
      .cmp_valid_0   (cmp_valid_0),
      .cmp_valid_1   (cmp_valid_1),
      .cmp_tag_0     (cmp_tag_0),
      .cmp_tag_1     (cmp_tag_1),
      .cmp_data_0    (cmp_data_0),
      .cmp_data_1    (cmp_data_1),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
`ifdef ROB_RETIRE_CNT_EN
      .retire_count  (retire_count),
`endif
      .rob_empty     (rob_empty)
   );

   always #5 clock = ~clock;

   // Reference model: in-flight instructions oldest-first.
   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic        wen;
      logic        done;
      logic [31:0] data;
   } m_ent_t;

   m_ent_t      rob[$];
   int          m_tail;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int unsigned m_ret;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic model_reset();
      rob.delete();
      m_tail  = 0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_ret   = 0;
   endtask

   task automatic idle_inputs();
      flush = 0;
      alloc_valid_0 = 0; alloc_valid_1 = 0;
      alloc_rd_0 = '0; alloc_rd_1 = '0;
      alloc_wen_0 = 0; alloc_wen_1 = 0;
      cmp_valid_0 = 0; cmp_valid_1 = 0;
      cmp_tag_0 = '0; cmp_tag_1 = '0;
      cmp_data_0 = '0; cmp_data_1 = '0;
   endtask

   // One clock of architectural behaviour from the current inputs.
   task automatic model_step();
      bit     ready;
      bit     cm;
      m_ent_t e;
      if (flush) begin
         rob.delete();
         m_tail = 0;
         m_we = 1'b0;
         return;
      end
      ready = (DEPTH - rob.size()) >= 2;
      cm = (rob.size() > 0) && rob[0].done;
      if (cm) begin
         m_we    = rob[0].wen && (rob[0].rd != 0);
         m_waddr = rob[0].rd;
         m_wdata = rob[0].data;
         m_ret++;
      end else begin
         m_we = 1'b0;
      end
      foreach (rob[i]) begin
         if (cmp_valid_0 && rob[i].tag == int'(cmp_tag_0)) begin
            rob[i].done = 1; rob[i].data = cmp_data_0;
         end
      end
      foreach (rob[i]) begin
         if (cmp_valid_1 && rob[i].tag == int'(cmp_tag_1)) begin
            rob[i].done = 1; rob[i].data = cmp_data_1;
         end
      end
      if (cm) void'(rob.pop_front());
      if (ready && alloc_valid_0) begin
         e = '{m_tail, alloc_rd_0, alloc_wen_0, 1'b0, 32'd0};
         rob.push_back(e);
         m_tail = (m_tail + 1) % DEPTH;
      end
      if (ready && alloc_valid_1) begin
         e = '{m_tail, alloc_rd_1, alloc_wen_1, 1'b0, 32'd0};
         rob.push_back(e);
         m_tail = (m_tail + 1) % DEPTH;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();
   endtask

   task automatic alloc2(input logic [4:0] r0, input logic [4:0] r1);
      alloc_valid_0 = 1; alloc_rd_0 = r0; alloc_wen_0 = 1;
      alloc_valid_1 = 1; alloc_rd_1 = r1; alloc_wen_1 = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      #2;
      n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b exp 0", rf_we); end
      n_chk++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
      n_chk++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
      n_chk++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b exp 1", rob_empty); end
      n_chk++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
      n_chk++; if (alloc_tag_0 !== 3'd0) begin n_err++; $display("FAIL reset_tag0 got %0d exp 0", alloc_tag_0); end
`ifdef ROB_RETIRE_CNT_EN
      n_chk++; if (retire_count !== 32'd0) begin n_err++; $display("FAIL reset_retire got %0d exp 0", retire_count); end
`endif
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_basic_commit();
      alloc2(5'd5, 5'd6);
      #1;
      n_chk++; if (alloc_tag_0 !== 3'd0) begin n_err++; $display("FAIL basic_tag0 got %0d exp 0", alloc_tag_0); end
      n_chk++; if (alloc_tag_1 !== 3'd1) begin n_err++; $display("FAIL basic_tag1 got %0d exp 1", alloc_tag_1); end
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd1; cmp_data_0 = 32'hBBBB;
      step();
      idle_inputs();
      cmp_valid_1 = 1; cmp_tag_1 = 3'd0; cmp_data_1 = 32'hAAAA;
      step();
      idle_inputs();
      n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL basic_early got %0b exp 0", rf_we); end
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hAAAA}) begin n_err++; $display("FAIL basic_c0 got %0b/%0d/%h exp 1/5/aaaa", rf_we, rf_waddr, rf_wdata); end
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'hBBBB}) begin n_err++; $display("FAIL basic_c1 got %0b/%0d/%h exp 1/6/bbbb", rf_we, rf_waddr, rf_wdata); end
      step();
      n_chk++; if ({rf_we, rf_waddr, rob_empty} !== {1'b0, 5'd6, 1'b1}) begin n_err++; $display("FAIL basic_idle got %0b/%0d/%0b exp 0/6/1", rf_we, rf_waddr, rob_empty); end
   endtask

   task automatic test_fill_wrap();
      do_reset();
      for (int p = 0; p < 4; p++) begin
         alloc2(5'(2 * p + 1), 5'(2 * p + 2));
         step();
      end
      idle_inputs();
      n_chk++; if ({alloc_ready, rob_empty} !== 2'b00) begin n_err++; $display("FAIL full_ready got %0b%0b exp 00", alloc_ready, rob_empty); end
      alloc2(5'd20, 5'd21);
      step();
      n_chk++; if (alloc_tag_0 !== 3'd0) begin n_err++; $display("FAIL full_drop got tag %0d exp 0", alloc_tag_0); end
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd0; cmp_data_0 = 32'h100;
      step();
      idle_inputs();
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h100}) begin n_err++; $display("FAIL full_c0 got %0b/%0d/%h exp 1/1/100", rf_we, rf_waddr, rf_wdata); end
      n_chk++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL cnt7_ready got %0b exp 0", alloc_ready); end
      cmp_valid_0 = 1; cmp_tag_0 = 3'd1; cmp_data_0 = 32'h101;
      step();
      idle_inputs();
      step();
      n_chk++; if ({rf_we, rf_waddr} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL full_c1 got %0b/%0d exp 1/2", rf_we, rf_waddr); end
      n_chk++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL cnt6_ready got %0b exp 1", alloc_ready); end
      alloc2(5'd22, 5'd23);
      #1;
      n_chk++; if ({alloc_tag_0, alloc_tag_1} !== {3'd0, 3'd1}) begin n_err++; $display("FAIL wrap_tags got %0d/%0d exp 0/1", alloc_tag_0, alloc_tag_1); end
      step();
      idle_inputs();
      n_chk++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL refill_ready got %0b exp 0", alloc_ready); end
   endtask

   task automatic test_zero_rd();
      do_reset();
      alloc_valid_0 = 1; alloc_rd_0 = 5'd0; alloc_wen_0 = 1;
      alloc_valid_1 = 1; alloc_rd_1 = 5'd7; alloc_wen_1 = 0;
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd0; cmp_data_0 = 32'h11;
      cmp_valid_1 = 1; cmp_tag_1 = 3'd1; cmp_data_1 = 32'h22;
      step();
      idle_inputs();
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata, rob_empty} !== {1'b0, 5'd0, 32'h11, 1'b0}) begin n_err++; $display("FAIL rd0 got %0b/%0d/%h/%0b exp 0/0/11/0", rf_we, rf_waddr, rf_wdata, rob_empty); end
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata, rob_empty} !== {1'b0, 5'd7, 32'h22, 1'b1}) begin n_err++; $display("FAIL wen0 got %0b/%0d/%h/%0b exp 0/7/22/1", rf_we, rf_waddr, rf_wdata, rob_empty); end
`ifdef ROB_RETIRE_CNT_EN
      n_chk++; if (retire_count !== 32'd2) begin n_err++; $display("FAIL retire_cnt got %0d exp 2", retire_count); end
`endif
   endtask

   task automatic test_flush();
      do_reset();
      alloc2(5'd1, 5'd2);
      step();
      alloc2(5'd3, 5'd4);
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd2; cmp_data_0 = 32'h2;
      cmp_valid_1 = 1; cmp_tag_1 = 3'd1; cmp_data_1 = 32'h1;
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd0; cmp_data_0 = 32'h0;
      step();
      idle_inputs();
      flush = 1;
      step();
      flush = 0;
      n_chk++; if ({rf_we, rob_empty, alloc_ready} !== 3'b011) begin n_err++; $display("FAIL flush_now got %0b%0b%0b exp 011", rf_we, rob_empty, alloc_ready); end
      step();
      n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL flush_after1 got %0b exp 0", rf_we); end
      step();
      n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL flush_after2 got %0b exp 0", rf_we); end
      alloc_valid_0 = 1; alloc_rd_0 = 5'd9; alloc_wen_0 = 1;
      #1;
      n_chk++; if (alloc_tag_0 !== 3'd0) begin n_err++; $display("FAIL flush_tag got %0d exp 0", alloc_tag_0); end
      step();
      idle_inputs();
   endtask

   task automatic test_dual_cmp();
      do_reset();
      alloc2(5'd8, 5'd9);
      step();
      alloc2(5'd10, 5'd11);
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd2; cmp_data_0 = 32'h1;
      cmp_valid_1 = 1; cmp_tag_1 = 3'd2; cmp_data_1 = 32'h2;
      step();
      cmp_tag_0 = 3'd0; cmp_data_0 = 32'h30;
      cmp_tag_1 = 3'd1; cmp_data_1 = 32'h31;
      step();
      idle_inputs();
      step();
      n_chk++; if ({rf_waddr, rf_wdata} !== {5'd8, 32'h30}) begin n_err++; $display("FAIL dual_c0 got %0d/%h exp 8/30", rf_waddr, rf_wdata); end
      step();
      step();
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h2}) begin n_err++; $display("FAIL dual_win got %0b/%0d/%h exp 1/10/2", rf_we, rf_waddr, rf_wdata); end
      n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {m_we, m_waddr, m_wdata}) begin n_err++; $display("FAIL dual_model got %0b/%0d/%h exp %0b/%0d/%h", rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc2(5'd12, 5'd13);
      step();
      idle_inputs();
      cmp_valid_0 = 1; cmp_tag_0 = 3'd0; cmp_data_0 = 32'h55;
      cmp_valid_1 = 1; cmp_tag_1 = 3'd1; cmp_data_1 = 32'h66;
      step();
      idle_inputs();
      step();
      n_chk++; if ({rf_we, rf_waddr} !== {1'b1, 5'd12}) begin n_err++; $display("FAIL areset_pre got %0b/%0d exp 1/12", rf_we, rf_waddr); end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_chk++; if ({rf_we, rob_empty, alloc_ready} !== 3'b011) begin n_err++; $display("FAIL areset_now got %0b%0b%0b exp 011", rf_we, rob_empty, alloc_ready); end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step();
      n_chk++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL areset_post1 got %0b exp 0", rf_we); end
      step();
      n_chk++; if ({rf_we, rob_empty} !== 2'b01) begin n_err++; $display("FAIL areset_post2 got %0b%0b exp 01", rf_we, rob_empty); end
`ifdef ROB_RETIRE_CNT_EN
      n_chk++; if (retire_count !== 32'd0) begin n_err++; $display("FAIL areset_retire got %0d exp 0", retire_count); end
`endif
   endtask

   task automatic test_random();
      logic [2:0] e_t0;
      logic [2:0] e_t1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         flush = ($urandom_range(0, 59) == 0);
         alloc_valid_0 = 1'($urandom_range(0, 1));
         alloc_valid_1 = 1'($urandom_range(0, 1));
         alloc_rd_0 = 5'($urandom_range(0, 31));
         alloc_rd_1 = 5'($urandom_range(0, 31));
         alloc_wen_0 = ($urandom_range(0, 3) != 0);
         alloc_wen_1 = ($urandom_range(0, 3) != 0);
         cmp_valid_0 = ($urandom_range(0, 9) < 6);
         cmp_valid_1 = ($urandom_range(0, 9) < 4);
         cmp_data_0 = $urandom;
         cmp_data_1 = $urandom;
         if (rob.size() > 0 && $urandom_range(0, 4) != 0)
            cmp_tag_0 = 3'(rob[$urandom_range(0, rob.size() - 1)].tag);
         else
            cmp_tag_0 = 3'($urandom_range(0, 7));
         if (rob.size() > 0 && $urandom_range(0, 4) != 0)
            cmp_tag_1 = 3'(rob[$urandom_range(0, rob.size() - 1)].tag);
         else
            cmp_tag_1 = 3'($urandom_range(0, 7));
         #1;
         e_t0 = 3'(m_tail);
         e_t1 = 3'((m_tail + int'(alloc_valid_0)) % DEPTH);
         n_chk++; if (alloc_ready !== ((DEPTH - rob.size()) >= 2)) begin n_err++; $display("FAIL rnd_ready c%0d got %0b size %0d", c, alloc_ready, rob.size()); end
         n_chk++; if (rob_empty !== (rob.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d got %0b size %0d", c, rob_empty, rob.size()); end
         n_chk++; if ({alloc_tag_0, alloc_tag_1} !== {e_t0, e_t1}) begin n_err++; $display("FAIL rnd_tags c%0d got %0d/%0d exp %0d/%0d", c, alloc_tag_0, alloc_tag_1, e_t0, e_t1); end
         step();
         n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {m_we, m_waddr, m_wdata}) begin n_err++; $display("FAIL rnd_rf c%0d got %0b/%0d/%h exp %0b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
`ifdef ROB_RETIRE_CNT_EN
         n_chk++; if (retire_count !== 32'(m_ret)) begin n_err++; $display("FAIL rnd_retire c%0d got %0d exp %0d", c, retire_count, m_ret); end
`endif
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_commit();
      test_fill_wrap();
      test_zero_rd();
      test_flush();
      test_dual_cmp();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
